ps2_mouse_packet_rx: RTL and testbench

Receives the serial PS/2 stream from the mouse and assembles the standard 3-byte movement packet into parallel button and displacement outputs. It sits directly downstream of the mouse clock divider and consumes its divided square wave as a slow timebase for frame-timeout supervision. Its packet outputs feed the cursor and position logic.

---
 rtl/ps2_mouse_packet_rx_pkg.sv | 46 ++++
 rtl/ps2_frame_rx.sv | 117 +++++++++++
 rtl/ps2_mouse_packet_rx.sv | 131 +++++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_packet_rx_pkg.sv
// ps2_mouse_packet_rx_pkg
//   Shared definitions for the PS/2 mouse receive path: the frame FSM state
//   encoding, the bit positions of the fields in packet byte 0, the frame
//   length, the decoded packet record, and the helper that turns three raw
//   bytes into that record.
package ps2_mouse_packet_rx_pkg;

    typedef enum logic [1:0] {
        FRM_IDLE   = 2'd0,
        FRM_DATA   = 2'd1,
        FRM_PARITY = 2'd2,
        FRM_STOP   = 2'd3
    } frame_state_t;

    // Byte 0 field positions
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_LEN = 11;
    localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

    typedef struct packed {
        logic [2:0] buttons;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       x_ovf;
        logic       y_ovf;
    } mouse_pkt_t;

    function automatic mouse_pkt_t decode_packet(input logic [7:0] b0,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
        mouse_pkt_t p;
        p.buttons = b0[2:0];
        p.dx      = {b0[B0_XSIGN], b1};
        p.dy      = {b0[B0_YSIGN], b2};
        p.x_ovf   = b0[B0_XOVF];
        p.y_ovf   = b0[B0_YOVF];
        return p;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Synchronizes the raw PS/2 clock/data lines, detects PS/2 clock falling
//   edges and runs the 11-bit frame FSM (start, 8 data LSB first, odd parity,
//   stop).
// Ports:
//   Clk, Reset      system clock, synchronous active-high reset
//   Ps2_Clk/Data    raw asynchronous PS/2 lines
//   Abort           forces the FSM back to IDLE (timeout from the top)
//   Rx_Byte         assembled data byte, valid while Byte_Valid is high
//   Byte_Valid      combinational pulse: good frame completed this cycle
//   Frame_Err       combinational pulse: bad parity or bad stop bit
//   Fall            combinational pulse: synchronized PS/2 clock falling edge
//   Busy            FSM is not in IDLE
module ps2_frame_rx
    import ps2_mouse_packet_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Ps2_Clk,
    input  logic       Ps2_Data,
    input  logic       Abort,
    output logic [7:0] Rx_Byte,
    output logic       Byte_Valid,
    output logic       Frame_Err,
    output logic       Fall,
    output logic       Busy
);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   bit_in;

    // Synchronizer flops idle at the line's released level (1).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], Ps2_Clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], Ps2_Data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign Fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    frame_state_t state, state_nxt;
    logic [2:0]   bit_cnt, bit_cnt_nxt;
    logic [7:0]   shreg, shreg_nxt;
    logic         par_ok, par_ok_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= FRM_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par_ok  <= par_ok_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_ok_nxt  = par_ok;
        Byte_Valid  = 1'b0;
        Frame_Err   = 1'b0;
        case (state)
            FRM_IDLE: begin
                // A start bit of 1 is line noise; stay put.
                if (Fall && !bit_in) begin
                    state_nxt   = FRM_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            FRM_DATA: begin
                if (Fall) begin
                    shreg_nxt = {bit_in, shreg[7:1]};
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1))
                        state_nxt = FRM_PARITY;
                    else
                        bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            FRM_PARITY: begin
                if (Fall) begin
                    par_ok_nxt = ^{shreg, bit_in};
                    state_nxt  = FRM_STOP;
                end
            end
            FRM_STOP: begin
                if (Fall) begin
                    if (par_ok && bit_in) Byte_Valid = 1'b1;
                    else                  Frame_Err  = 1'b1;
                    state_nxt = FRM_IDLE;
                end
            end
            default: state_nxt = FRM_IDLE;
        endcase
        // Abort is only raised in cycles without an edge, so it never
        // collides with the pulses above.
        if (Abort) state_nxt = FRM_IDLE;
    end

    assign Rx_Byte = shreg;
    assign Busy    = (state != FRM_IDLE);

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx
//   Assembles 3-byte PS/2 mouse movement packets from the frame receiver and
//   supervises frame/packet progress with a timeout counted in Tick_Clk
//   rising edges.
// Ports:
//   Clk, Reset           system clock, synchronous active-high reset
//   Tick_Clk             slow divided clock, sampled as data
//   Ps2_Clk, Ps2_Data    raw asynchronous PS/2 lines
//   Packet_Valid         1-cycle pulse per accepted packet
//   Buttons/Dx/Dy/X_Ovf/Y_Ovf  decoded packet fields, held between packets
//   Frame_Err            1-cycle pulse per aborted frame or packet
module ps2_mouse_packet_rx
    import ps2_mouse_packet_rx_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_TICKS = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick_Clk,
    input  logic       Ps2_Clk,
    input  logic       Ps2_Data,
    output logic       Packet_Valid,
    output logic [2:0] Buttons,
    output logic [8:0] Dx,
    output logic [8:0] Dy,
    output logic       X_Ovf,
    output logic       Y_Ovf,
    output logic       Frame_Err
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [7:0] rx_byte;
    logic       byte_valid, frm_err, fall, busy, abort;

    ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES)) u_frame (
        .Clk        (Clk),
        .Reset      (Reset),
        .Ps2_Clk    (Ps2_Clk),
        .Ps2_Data   (Ps2_Data),
        .Abort      (abort),
        .Rx_Byte    (rx_byte),
        .Byte_Valid (byte_valid),
        .Frame_Err  (frm_err),
        .Fall       (fall),
        .Busy       (busy)
    );

    // Tick_Clk synchronizer and rising-edge detect
    logic [1:0] tick_sync;
    logic       tick_prev, tick;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_sync <= 2'b11;
            tick_prev <= 1'b1;
        end else begin
            tick_sync <= {tick_sync[0], Tick_Clk};
            tick_prev <= tick_sync[1];
        end
    end

    assign tick = ~tick_prev & tick_sync[1];

    // Timeout supervision
    logic [1:0]    idx;
    logic [TW-1:0] tick_cnt;
    logic          active;

    assign active = busy || (idx != 2'd0);
    // A PS/2 edge in the same cycle as the final tick wins.
    assign abort  = active && !fall && tick && (tick_cnt == TW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge Clk) begin
        if (Reset || fall || !active || abort)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Packet assembler
    logic [7:0] byte0, byte1;
    mouse_pkt_t pkt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx          <= 2'd0;
            byte0        <= '0;
            byte1        <= '0;
            pkt          <= '0;
            Packet_Valid <= 1'b0;
            Frame_Err    <= 1'b0;
        end else begin
            Packet_Valid <= 1'b0;
            Frame_Err    <= 1'b0;
            if (frm_err || abort) begin
                Frame_Err <= 1'b1;
                idx       <= 2'd0;
            end else if (byte_valid) begin
                case (idx)
                    2'd0: begin
                        // Sync bit keeps the assembler aligned to packet starts.
                        if (rx_byte[B0_SYNC]) begin
                            byte0 <= rx_byte;
                            idx   <= 2'd1;
                        end else begin
                            Frame_Err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        byte1 <= rx_byte;
                        idx   <= 2'd2;
                    end
                    default: begin
                        pkt          <= decode_packet(byte0, byte1, rx_byte);
                        Packet_Valid <= 1'b1;
                        idx          <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign Buttons = pkt.buttons;
    assign Dx      = pkt.dx;
    assign Dy      = pkt.dy;
    assign X_Ovf   = pkt.x_ovf;
    assign Y_Ovf   = pkt.y_ovf;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// tb_ps2_mouse_packet_rx
//   Scoreboard bench: each stimulus pushes the event it should produce
//   (packet contents or a frame error); a monitor pops and compares on every
//   Packet_Valid / Frame_Err pulse.
module tb_ps2_mouse_packet_rx;

    localparam int H      = 20;   // PS/2 half bit period, in Clk cycles
    localparam int TICK_P = 200;  // Tick_Clk period, in Clk cycles

    logic       Clk = 1'b0, Reset = 1'b1, Tick_Clk = 1'b0;
    logic       Ps2_Clk = 1'b1, Ps2_Data = 1'b1;
    logic       Packet_Valid, X_Ovf, Y_Ovf, Frame_Err;
    logic [2:0] Buttons;
    logic [8:0] Dx, Dy;

    ps2_mouse_packet_rx #(.SYNC_STAGES(2), .TIMEOUT_TICKS(3)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Tick_Clk     (Tick_Clk),
        .Ps2_Clk      (Ps2_Clk),
        .Ps2_Data     (Ps2_Data),
        .Packet_Valid (Packet_Valid),
        .Buttons      (Buttons),
        .Dx           (Dx),
        .Dy           (Dy),
        .X_Ovf        (X_Ovf),
        .Y_Ovf        (Y_Ovf),
        .Frame_Err    (Frame_Err)
    );

    always #5 Clk = ~Clk;
    always #(TICK_P * 5) Tick_Clk = ~Tick_Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit         err;
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       xo;
        logic       yo;
    } ev_t;

    ev_t q[$];

    function automatic ev_t pkt_ev(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2);
        ev_t e;
        e.err = 1'b0;
        e.btn = b0[2:0];
        e.dx  = {b0[4], b1};
        e.dy  = {b0[5], b2};
        e.xo  = b0[6];
        e.yo  = b0[7];
        return e;
    endfunction

    function automatic ev_t err_ev();
        ev_t e;
        e.err = 1'b1;
        e.btn = '0;
        e.dx  = '0;
        e.dy  = '0;
        e.xo  = 1'b0;
        e.yo  = 1'b0;
        return e;
    endfunction

    // Monitor / scoreboard
    ev_t mon_e;
    always @(negedge Clk) begin
        if (!Reset && (Packet_Valid || Frame_Err)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, Packet_Valid, Frame_Err}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_excl", {31'd0, Packet_Valid & Frame_Err}, 32'd0);
                chk("pulse_kind", {31'd0, Frame_Err}, {31'd0, mon_e.err});
                if (!mon_e.err) begin
                    chk("buttons", {29'd0, Buttons}, {29'd0, mon_e.btn});
                    chk("dx", {23'd0, Dx}, {23'd0, mon_e.dx});
                    chk("dy", {23'd0, Dy}, {23'd0, mon_e.dy});
                    chk("x_ovf", {31'd0, X_Ovf}, {31'd0, mon_e.xo});
                    chk("y_ovf", {31'd0, Y_Ovf}, {31'd0, mon_e.yo});
                end
            end
        end
    end

    // Device-side PS/2 bit: data set while clock high, then clock low.
    task automatic ps2_bit(input logic b);
        @(negedge Clk) Ps2_Data = b;
        repeat (H) @(negedge Clk);
        Ps2_Clk = 1'b0;
        repeat (H) @(negedge Clk);
        Ps2_Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                              input logic stop = 1'b1, input int nbits = 11,
                              input int gap = 50);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        Ps2_Data = 1'b1;
        repeat (gap) @(negedge Clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        q.push_back(pkt_ev(b0, b1, b2));
        send_frame(b0);
        send_frame(b1);
        send_frame(b2);
    endtask

    task automatic settle(input string tag);
        repeat (100) @(negedge Clk);
        chk(tag, q.size(), 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, Packet_Valid, Frame_Err, Buttons, Dx, Dy, X_Ovf, Y_Ovf};
    endfunction

    initial begin
        #(2_000_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        chk("reset_outs", all_outs(), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("post_reset_outs", all_outs(), 32'd0);

        // Basic packet
        send_pkt(8'h09, 8'h05, 8'hFB);
        settle("pkt1_done");
        chk("hold_dx", {23'd0, Dx}, 32'h005);

        // Bad parity, then recovery
        q.push_back(err_ev());
        send_frame(8'h18, 1'b1);
        send_pkt(8'h28, 8'h7F, 8'h01);
        settle("parity_done");

        // Missing sync bit on byte 0
        q.push_back(err_ev());
        send_frame(8'h00);
        send_pkt(8'h08, 8'h10, 8'h20);
        settle("sync_done");

        // Bad stop bit on byte 1
        q.push_back(err_ev());
        send_frame(8'h08);
        send_frame(8'h33, 1'b0, 1'b0);
        send_pkt(8'h29, 8'h05, 8'hFB);
        settle("stop_done");

        // Timeout after two bytes: the 3rd tick after the last edge aborts
        q.push_back(err_ev());
        send_frame(8'h18);
        send_frame(8'h44, 1'b0, 1'b1, 11, 0);
        repeat (2 * TICK_P - 10 - H) @(negedge Clk);
        chk("timeout_not_early", q.size(), 32'd1);
        repeat (TICK_P + 20) @(negedge Clk);
        chk("timeout_fired", q.size(), 32'd0);
        send_pkt(8'h38, 8'hFF, 8'hFF);
        settle("timeout_done");

        // Reset in the middle of byte 1
        send_frame(8'h08);
        send_frame(8'h55, 1'b0, 1'b1, 5, 0);
        @(negedge Clk) Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("midreset_outs", all_outs(), 32'd0);
        Reset = 1'b0;
        Ps2_Data = 1'b1;
        repeat (10) @(negedge Clk);
        chk("after_midreset_outs", all_outs(), 32'd0);
        send_pkt(8'hCA, 8'h12, 8'h34);
        settle("final_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
